// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, redirect buffer for redirects seen under stall, combinational ROM read.
// The instruction ROM holds an index-tagged pattern (0xC0DE_0000 | word index).
// Define IF_ADDR_CHECK_EN to add fetch_err_o and force a nop on fetches outside the ROM window or misaligned.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_DEPTH = 1024,
  parameter string       IM_FILE  = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
`ifdef IF_ADDR_CHECK_EN
  output logic        fetch_err_o,
`endif
  output logic        redir_pending_o
);

  localparam int AW = $clog2(IM_DEPTH);

  logic [31:0] rom [IM_DEPTH];

  initial begin
    for (int i = 0; i < IM_DEPTH; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
  end

  logic [31:0] pc_q = PC_RESET;
  logic [31:0] pc_d;
  logic        pend_v_q = 1'b0;
  logic        pend_v_d;
  logic [31:0] pend_tgt_q = '0;
  logic [31:0] pend_tgt_d;

  logic [31:0]   pc_plus4;
  logic [31:0]   rom_offs;
  logic [AW-1:0] rom_idx;
  logic [31:0]   rom_word;

  assign pc_plus4 = pc_q + 32'd4;
  assign rom_offs = pc_q - PC_RESET;
  assign rom_idx  = AW'(rom_offs >> 2);
  assign rom_word = rom[rom_idx];

  always_comb begin
    pc_d       = pc_plus4;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (stall) begin
      pc_d = pc_q;
      if (redir_valid) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = redir_target;
      end
    end else if (redir_valid) begin
      pc_d     = redir_target;
      pend_v_d = 1'b0;
    end else if (pend_v_q) begin
      pc_d     = pend_tgt_q;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef IF_ADDR_CHECK_EN
  logic [32:0] win_end;
  logic        addr_bad;

  assign win_end  = {1'b0, PC_RESET} + 33'(4 * IM_DEPTH);
  assign addr_bad = (pc_q < PC_RESET) || ({1'b0, pc_q} >= win_end) || (pc_q[1:0] != 2'b00);

  always_comb begin
    fetch_err_o = addr_bad;
    instr_o     = addr_bad ? 32'h0000_0000 : rom_word;
  end
`else
  assign instr_o = rom_word;
`endif

  assign pc_o            = pc_q;
  assign pc4_o           = pc_plus4;
  assign redir_pending_o = pend_v_q;

endmodule
